// File: rtl/input_feeder.sv
// input_feeder: host-to-pipeline byte buffer with three show-ahead FIFOs.
// Optional dropped-push counter at address 110 when OVF_COUNT_EN is defined.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   chipselect, write, read     Avalon-MM slave strobes
//   address[2:0], writedata[7:0] register/FIFO select and host byte
//   readdata[7:0]               registered read response (1-cycle latency)
//   dataN[7:0], validN          channel N head byte and valid (N = 1..3)
//   readyN                      channel N pipeline accepts head
//
// Write map: 000 enable, 001-011 push FIFO 1-3, 100 flush mask,
//            110 clear drop counter (OVF_COUNT_EN only).
// Read map:  000 enable, 001-011 fill counts, 100 full/empty status,
//            101 overflow bits, 110 drop counter (OVF_COUNT_EN only).

module input_feeder #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       chipselect,
    input  logic       write,
    input  logic       read,
    input  logic [2:0] address,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic [7:0] data1,
    output logic [7:0] data2,
    output logic [7:0] data3,
    output logic       valid1,
    output logic       valid2,
    output logic       valid3,
    input  logic       ready1,
    input  logic       ready2,
    input  logic       ready3
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [3][DEPTH];
    logic [AW-1:0] r_wp  [3];
    logic [AW-1:0] r_rp  [3];
    logic [AW:0]   r_cnt [3];
    logic [2:0]    r_en;
    logic [2:0]    r_ovf;
    logic [7:0]    r_readdata;

    logic       w_wr;
    logic       w_rd;
    logic [2:0] w_rdy;
    logic [2:0] w_full;
    logic [2:0] w_empty;
    logic [2:0] w_valid;
    logic [2:0] w_pop;
    logic [2:0] w_push;
    logic [2:0] w_push_ok;
    logic [2:0] w_drop;
    logic [2:0] w_flush;

    assign w_wr  = chipselect && write;
    assign w_rd  = chipselect && read;
    assign w_rdy = {ready3, ready2, ready1};

    always_comb begin
        w_full    = '0;
        w_empty   = '0;
        w_valid   = '0;
        w_pop     = '0;
        w_push    = '0;
        w_push_ok = '0;
        w_drop    = '0;
        w_flush   = '0;
        for (int n = 0; n < 3; n++) begin
            w_full[n]    = (r_cnt[n] == FULL_CNT);
            w_empty[n]   = (r_cnt[n] == '0);
            w_valid[n]   = !w_empty[n] && r_en[n];
            w_pop[n]     = w_valid[n] && w_rdy[n];
            w_push[n]    = w_wr && (address == 3'(n + 1));
            // Full is judged on the pre-edge count: a same-cycle pop
            // does not make room for the push.
            w_push_ok[n] = w_push[n] && !w_full[n];
            w_drop[n]    = w_push[n] && w_full[n];
            w_flush[n]   = w_wr && (address == 3'd4) && writedata[n];
        end
    end

    // Storage carries no reset; pointers and counts define what is live.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 3; n++) begin
            if (w_push_ok[n]) begin
                r_mem[n][r_wp[n]] <= writedata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_en  <= '0;
            r_ovf <= '0;
            for (int n = 0; n < 3; n++) begin
                r_wp[n]  <= '0;
                r_rp[n]  <= '0;
                r_cnt[n] <= '0;
            end
        end else begin
            if (w_wr && (address == 3'd0)) begin
                r_en <= writedata[2:0];
            end
            for (int n = 0; n < 3; n++) begin
                // Flush dominates any pop on the same channel.
                if (w_flush[n]) begin
                    r_wp[n]  <= '0;
                    r_rp[n]  <= '0;
                    r_cnt[n] <= '0;
                    r_ovf[n] <= 1'b0;
                end else begin
                    if (w_push_ok[n]) begin
                        r_wp[n] <= r_wp[n] + 1'b1;
                    end
                    if (w_pop[n]) begin
                        r_rp[n] <= r_rp[n] + 1'b1;
                    end
                    if (w_push_ok[n] && !w_pop[n]) begin
                        r_cnt[n] <= r_cnt[n] + 1'b1;
                    end else if (w_pop[n] && !w_push_ok[n]) begin
                        r_cnt[n] <= r_cnt[n] - 1'b1;
                    end
                    if (w_drop[n]) begin
                        r_ovf[n] <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef OVF_COUNT_EN
    logic [7:0] r_ovf_cnt;

    // At most one push per cycle, so at most one drop per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf_cnt <= '0;
        end else if (w_wr && (address == 3'd6)) begin
            r_ovf_cnt <= '0;
        end else if ((|w_drop) && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
    end
`endif

    // Reads sample pre-edge state, so a same-cycle write is not visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (w_rd) begin
            case (address)
                3'd0:    r_readdata <= {5'b0, r_en};
                3'd1:    r_readdata <= 8'(r_cnt[0]);
                3'd2:    r_readdata <= 8'(r_cnt[1]);
                3'd3:    r_readdata <= 8'(r_cnt[2]);
                3'd4:    r_readdata <= {2'b0, w_full, w_empty};
                3'd5:    r_readdata <= {5'b0, r_ovf};
`ifdef OVF_COUNT_EN
                3'd6:    r_readdata <= r_ovf_cnt;
`endif
                default: r_readdata <= '0;
            endcase
        end else begin
            r_readdata <= '0;
        end
    end

    assign readdata = r_readdata;
    assign data1    = r_mem[0][r_rp[0]];
    assign data2    = r_mem[1][r_rp[1]];
    assign data3    = r_mem[2][r_rp[2]];
    assign valid1   = w_valid[0];
    assign valid2   = w_valid[1];
    assign valid3   = w_valid[2];

endmodule

// File: tb/tb_input_feeder.sv
// tb_input_feeder: self-checking bench for input_feeder.
// Queue-based reference model, directed scenarios plus random traffic.

module tb_input_feeder;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       chipselect = 1'b0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic [2:0] address = '0;
    logic [7:0] writedata = '0;
    logic [7:0] readdata;
    logic [7:0] data1, data2, data3;
    logic       valid1, valid2, valid3;
    logic       ready1 = 1'b0;
    logic       ready2 = 1'b0;
    logic       ready3 = 1'b0;

    logic [7:0] dout [3];
    logic [2:0] vout;

    int errors = 0;
    int checks = 0;

    bit [7:0] q [3][$];
    bit [2:0] m_en;
    bit [2:0] m_ovf;
    int       m_ocnt;
    bit [7:0] exp_rd;

    always #5 clk = ~clk;

    input_feeder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .chipselect(chipselect), .write(write), .read(read),
        .address(address), .writedata(writedata), .readdata(readdata),
        .data1(data1), .data2(data2), .data3(data3),
        .valid1(valid1), .valid2(valid2), .valid3(valid3),
        .ready1(ready1), .ready2(ready2), .ready3(ready3)
    );

    assign dout[0] = data1;
    assign dout[1] = data2;
    assign dout[2] = data3;
    assign vout    = {valid3, valid2, valid1};

    function automatic bit m_valid(int n);
        return (q[n].size() > 0) && m_en[n];
    endfunction

    function automatic bit [7:0] model_read(logic [2:0] a);
        bit [2:0] f, e;
        for (int n = 0; n < 3; n++) begin
            f[n] = (q[n].size() == DEPTH);
            e[n] = (q[n].size() == 0);
        end
        case (a)
            3'd0: return {5'b0, m_en};
            3'd1: return 8'(q[0].size());
            3'd2: return 8'(q[1].size());
            3'd3: return 8'(q[2].size());
            3'd4: return {2'b0, f, e};
            3'd5: return {5'b0, m_ovf};
`ifdef OVF_COUNT_EN
            3'd6: return 8'(m_ocnt);
`endif
            default: return 8'h00;
        endcase
    endfunction

    // Advance one clock: apply the rules to the model using the inputs
    // currently driven, then step past the edge.
    task automatic tick();
        bit [7:0] nrd;
        bit [2:0] rdy;
        bit       wr, rd;
        bit       full_pre [3];
        rdy = {ready3, ready2, ready1};
        wr  = chipselect && write;
        rd  = chipselect && read;
        if (reset) begin
            for (int n = 0; n < 3; n++) q[n].delete();
            m_en = '0; m_ovf = '0; m_ocnt = 0; nrd = '0;
        end else begin
            nrd = rd ? model_read(address) : 8'h00;
            for (int n = 0; n < 3; n++) full_pre[n] = (q[n].size() == DEPTH);
            for (int n = 0; n < 3; n++) begin
                if (m_valid(n) && rdy[n]) void'(q[n].pop_front());
            end
            if (wr && address >= 3'd1 && address <= 3'd3) begin
                int n;
                n = int'(address) - 1;
                if (full_pre[n]) begin
                    m_ovf[n] = 1'b1;
                    if (m_ocnt < 255) m_ocnt++;
                end else begin
                    q[n].push_back(writedata);
                end
            end
            if (wr && address == 3'd4) begin
                for (int n = 0; n < 3; n++) begin
                    if (writedata[n]) begin
                        q[n].delete();
                        m_ovf[n] = 1'b0;
                    end
                end
            end
            if (wr && address == 3'd0) m_en = writedata[2:0];
`ifdef OVF_COUNT_EN
            if (wr && address == 3'd6) m_ocnt = 0;
`endif
        end
        @(posedge clk);
        #1;
        exp_rd = nrd;
    endtask

    task automatic bus_wr(logic [2:0] a, logic [7:0] d);
        chipselect = 1'b1; write = 1'b1; read = 1'b0;
        address = a; writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_rd(logic [2:0] a);
        chipselect = 1'b1; write = 1'b0; read = 1'b1;
        address = a;
        tick();
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (vout !== 3'b000) begin
            errors++;
            $display("FAIL reset_valid got=%b exp=000", vout);
        end
        checks++;
        if (readdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_readdata got=%h exp=00", readdata);
        end
        bus_rd(3'd4);
        checks++;
        if (readdata !== 8'h07) begin
            errors++;
            $display("FAIL reset_status got=%h exp=07", readdata);
        end
        bus_rd(3'd0);
        checks++;
        if (readdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_enable got=%h exp=00", readdata);
        end
    endtask

    task automatic test_basic();
        bus_wr(3'd0, 8'h07);
        ready1 = 1'b1;
        chipselect = 1'b1; write = 1'b1; address = 3'd1; writedata = 8'hA1;
        tick();
        checks++;
        if (valid1 !== 1'b1 || data1 !== 8'hA1) begin
            errors++;
            $display("FAIL basic_first got=%b/%h exp=1/a1", valid1, data1);
        end
        writedata = 8'hA2;
        tick();
        chipselect = 1'b0; write = 1'b0;
        checks++;
        if (valid1 !== 1'b1 || data1 !== 8'hA2) begin
            errors++;
            $display("FAIL basic_second got=%b/%h exp=1/a2", valid1, data1);
        end
        tick();
        checks++;
        if (valid1 !== 1'b0) begin
            errors++;
            $display("FAIL basic_drained got=%b exp=0", valid1);
        end
        bus_rd(3'd1);
        checks++;
        if (readdata !== 8'h00) begin
            errors++;
            $display("FAIL basic_count got=%h exp=00", readdata);
        end
    endtask

    task automatic test_overflow();
        ready1 = 1'b0;
        chipselect = 1'b1; write = 1'b1; address = 3'd1;
        for (int i = 0; i < 17; i++) begin
            writedata = 8'($urandom);
            tick();
            checks++;
            if (valid1 !== m_valid(0) || (m_valid(0) && data1 !== q[0][0])) begin
                errors++;
                $display("FAIL ovf_fill%0d got=%b/%h", i, valid1, data1);
            end
        end
        chipselect = 1'b0; write = 1'b0;
        bus_rd(3'd1);
        checks++;
        if (readdata !== 8'd16) begin
            errors++;
            $display("FAIL ovf_count got=%0d exp=16", readdata);
        end
        bus_rd(3'd4);
        checks++;
        if (readdata !== exp_rd || readdata[3] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_status got=%h exp=%h", readdata, exp_rd);
        end
        bus_rd(3'd5);
        checks++;
        if (readdata !== 8'h01) begin
            errors++;
            $display("FAIL ovf_bits got=%h exp=01", readdata);
        end
        bus_rd(3'd6);
        checks++;
`ifdef OVF_COUNT_EN
        if (readdata !== 8'h01) begin
`else
        if (readdata !== 8'h00) begin
`endif
            errors++;
            $display("FAIL ovf_counter got=%h exp=%h", readdata, exp_rd);
        end
        ready1 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (valid1 !== m_valid(0) || (m_valid(0) && data1 !== q[0][0])) begin
                errors++;
                $display("FAIL ovf_drain%0d got=%b/%h", i, valid1, data1);
            end
            tick();
        end
        checks++;
        if (valid1 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_17th got=%b exp=0", valid1);
        end
        bus_wr(3'd4, 8'h01);
        bus_rd(3'd5);
        checks++;
        if (readdata !== 8'h00) begin
            errors++;
            $display("FAIL ovf_flush_clear got=%h exp=00", readdata);
        end
    endtask

    task automatic test_enable();
        bus_wr(3'd0, 8'h00);
        ready2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_wr(3'd2, 8'($urandom));
            checks++;
            if (valid2 !== 1'b0) begin
                errors++;
                $display("FAIL en_gated%0d got=%b exp=0", i, valid2);
            end
        end
        tick();
        bus_rd(3'd2);
        checks++;
        if (readdata !== 8'd5) begin
            errors++;
            $display("FAIL en_count got=%0d exp=5", readdata);
        end
        bus_wr(3'd0, 8'h02);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (valid2 !== m_valid(1) || (m_valid(1) && data2 !== q[1][0])) begin
                errors++;
                $display("FAIL en_drain%0d got=%b/%h", i, valid2, data2);
            end
            tick();
        end
        checks++;
        if (valid2 !== 1'b0) begin
            errors++;
            $display("FAIL en_empty got=%b exp=0", valid2);
        end
        ready2 = 1'b0;
    endtask

    task automatic test_flush();
        bus_wr(3'd0, 8'h07);
        ready1 = 1'b0; ready3 = 1'b0;
        bus_wr(3'd1, 8'h11);
        bus_wr(3'd1, 8'h12);
        for (int i = 0; i < 3; i++) bus_wr(3'd3, 8'($urandom));
        ready3 = 1'b1;
        bus_wr(3'd4, 8'h04);
        checks++;
        if (valid3 !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid got=%b exp=0", valid3);
        end
        checks++;
        if (valid1 !== 1'b1 || data1 !== 8'h11) begin
            errors++;
            $display("FAIL flush_other got=%b/%h exp=1/11", valid1, data1);
        end
        bus_rd(3'd3);
        checks++;
        if (readdata !== 8'h00) begin
            errors++;
            $display("FAIL flush_count got=%h exp=00", readdata);
        end
        bus_rd(3'd1);
        checks++;
        if (readdata !== 8'd2) begin
            errors++;
            $display("FAIL flush_count1 got=%h exp=02", readdata);
        end
        bus_rd(3'd5);
        checks++;
        if (readdata[2] !== 1'b0 || readdata !== exp_rd) begin
            errors++;
            $display("FAIL flush_ovf got=%h exp=%h", readdata, exp_rd);
        end
        ready3 = 1'b0;
        bus_wr(3'd4, 8'h07);
    endtask

    task automatic test_back_to_back();
        bus_wr(3'd0, 8'h07);
        ready1 = 1'b1;
        chipselect = 1'b1; write = 1'b1; address = 3'd1;
        for (int i = 0; i < 40; i++) begin
            writedata = 8'($urandom);
            tick();
            checks++;
            if (valid1 !== 1'b1 || data1 !== q[0][0]) begin
                errors++;
                $display("FAIL b2b%0d got=%b/%h exp=1/%h",
                         i, valid1, data1, q[0][0]);
            end
        end
        chipselect = 1'b0; write = 1'b0;
        tick();
        bus_rd(3'd1);
        checks++;
        if (readdata !== 8'h00) begin
            errors++;
            $display("FAIL b2b_count got=%h exp=00", readdata);
        end
        bus_rd(3'd5);
        checks++;
        if (readdata !== 8'h00) begin
            errors++;
            $display("FAIL b2b_ovf got=%h exp=00", readdata);
        end
        ready1 = 1'b0;
    endtask

    task automatic test_random();
        bus_wr(3'd0, 8'h07);
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            chipselect = ($urandom_range(0, 9) != 0);
            write = (r < 60);
            read = ($urandom_range(0, 1) == 1);
            address = 3'($urandom_range(0, 7));
            writedata = 8'($urandom);
            if (write && r < 45) address = 3'($urandom_range(1, 3));
            if (write && address == 3'd0 && r > 20) writedata[2:0] = 3'b111;
            if (write && address == 3'd4 && r > 10) writedata[2:0] = 3'b000;
            ready1 = ($urandom_range(0, 2) == 0);
            ready2 = ($urandom_range(0, 2) == 0);
            ready3 = ($urandom_range(0, 3) != 0);
            tick();
            checks++;
            if (readdata !== exp_rd) begin
                errors++;
                $display("FAIL rnd_rd%0d got=%h exp=%h", i, readdata, exp_rd);
            end
            for (int n = 0; n < 3; n++) begin
                checks++;
                if (vout[n] !== m_valid(n) ||
                    (m_valid(n) && dout[n] !== q[n][0])) begin
                    errors++;
                    $display("FAIL rnd_ch%0d_%0d got=%b/%h exp=%b",
                             n + 1, i, vout[n], dout[n], m_valid(n));
                end
            end
        end
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
        ready1 = 1'b0; ready2 = 1'b0; ready3 = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus_wr(3'd4, 8'h07);
        bus_wr(3'd0, 8'h07);
        for (int n = 1; n <= 3; n++) begin
            for (int i = 0; i < 8; i++) bus_wr(3'(n), 8'($urandom));
        end
        chipselect = 1'b1; read = 1'b1; address = 3'd1;
        reset = 1'b1;
        tick();
        reset = 1'b0; chipselect = 1'b0; read = 1'b0;
        checks++;
        if (vout !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_valid got=%b exp=000", vout);
        end
        checks++;
        if (readdata !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_rd got=%h exp=00", readdata);
        end
        for (int n = 1; n <= 3; n++) begin
            bus_rd(3'(n));
            checks++;
            if (readdata !== 8'h00) begin
                errors++;
                $display("FAIL rstmid_cnt%0d got=%h exp=00", n, readdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_enable();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_feeder.md
Name: input_feeder

Overview:
Host-to-pipeline buffer: the write-side counterpart of the result readback buffer. The host pushes bytes over the Avalon-MM slave port (chipselect/write/address/writedata) into three per-channel FIFOs. Each FIFO streams to its processing pipeline through a valid/ready handshake. Control and status registers are readable on the same port.

Parameters:
DEPTH, 16, entries per channel FIFO; must be a power of two, minimum 2
AW, $clog2(DEPTH), FIFO pointer width; derived, not overridden

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
chipselect  in  1  slave select
write  in  1  write strobe, qualified by chipselect
read  in  1  read strobe, qualified by chipselect
address  in  3  register/FIFO select
writedata  in  8  host write byte
readdata  out  8  registered read response
data1, data2, data3  out  8  channel head byte to pipeline
valid1, valid2, valid3  out  1  channel head valid
ready1, ready2, ready3  in  1  pipeline accepts head

Behaviour:
- Reset: clears FIFOs (pointers and counts 0), enable reg 0, overflow bits 0, readdata 0, validN 0. Reset asserted mid-transfer discards all buffered data. Reset overrides all other activity.
- Write map, active when chipselect && write:
  - 001/010/011 push writedata into FIFO 1/2/3.
  - 000 enable reg <= writedata[2:0]; bit n-1 gates channel n.
  - 100 flush: each set bit of writedata[2:0] empties that FIFO and clears its overflow bit.
  - Other addresses: ignored.
- Full rule: a push to a full FIFO is dropped and sets sticky overflow bit n-1. Full is the pre-edge state, so the push is dropped even when a pop happens the same cycle.
- Push/pop: pop when validN && readyN. Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged. Pointers wrap modulo DEPTH. Count is AW+1 bits, range 0..DEPTH.
- Output: show-ahead. dataN = head entry; validN = !emptyN && enable[n-1], combinational from registered state. A byte pushed at edge k is visible on dataN/validN after edge k (1-cycle write-to-valid latency, including when the FIFO was empty). dataN is don't-care while validN = 0.
- Disabling a channel deasserts validN without discarding data.
- Flush wins over a pop or push to the same channel in the same cycle.
- Read map, active when chipselect && read; readdata updates at the next edge (1-cycle latency):
  - 000 {5'b0, enable}
  - 001/010/011 fill count of channel 1/2/3, zero-extended
  - 100 {2'b0, full3, full2, full1, empty3, empty2, empty1}
  - 101 {5'b0, overflow[2:0]}
  - Other addresses: 0
- When not (chipselect && read), readdata <= 0.
- Reads never pop data.
- Simultaneous read and write in the same cycle: the read returns pre-write state.

Optional Feature:
Macro OVF_COUNT_EN.
- Defined: adds an 8-bit saturating counter (max 255) of dropped pushes, summed across channels. A drop adds 1 per cycle (only one push per cycle is possible). Read at 110. Any write to 110 clears it. Reset clears it.
- Undefined: no counter; reads of 110 return 0; writes to 110 are ignored.

Test Plan:
- Reset, write 000 = 0x07, push 0xA1, 0xA2 to 001 with ready1 = 1 -> valid1 high the cycle after the first push; data1 = 0xA1 then 0xA2; valid1 low afterwards; read 001 returns 0.
- ready1 = 0, push 17 bytes to 001 with DEPTH = 16 -> read 001 = 16; read 100 bit3 = 1; read 101 = 0x01; 17th byte never emitted. With OVF_COUNT_EN, read 110 = 1.
- Fill FIFO 2 to 5 entries, enable = 0 -> valid2 = 0, count stays 5. Write 000 = 0x02 -> valid2 = 1 and 5 bytes drain in order.
- Push 3 bytes to 011, then write 100 = 0x04 in the same cycle ready3 = 1 -> count3 = 0, valid3 = 0, overflow3 = 0; the other channels are unaffected.
- Hold ready1 = 1 and alternate pushes every cycle for 40 cycles -> count stays ≤ 1, bytes emerge in order across pointer wrap, no overflow.
- Assert reset with all FIFOs half full -> all counts 0, validN = 0, readdata = 0 on the next cycle.
